simon_game_param: RTL and testbench

Parametrised Simon memory game core. It is the next generation of the 4-switch/64-entry Simon: switch width and sequence depth are configurable, and it adds a 2-bit difficulty level latched at reset, a round-score output, a WIN terminal state when the sequence memory fills, and an optional one-strike tolerance. It sits between the board switch/LED glue and the debounced user-clock button (pclk), which advances the game one step per press.

---
 rtl/simon_game_param.sv | 140 ++++++++++++++
 tb/tb_simon_game_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/simon_game_param.sv
// Parametrised Simon memory game core stepped by the debounced user clock (pclk).
// Optional one-strike tolerance is built when SIMON_STRIKE_EN is defined.
module simon_game_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [1:0]       level,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] pattern_leds,
  output logic [2:0]       mode_leds,
  output logic [CNT_W-1:0] score,
  output logic             strike
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    StInput,
    StPlayback,
    StRepeat,
    StDone,
    StWin
  } state_e;

  logic [WIDTH-1:0] mem [DEPTH];
  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] score_q;
  logic [AW-1:0]    idx_q;
  logic [1:0]       lvl_q;

  logic [CNT_W-1:0] last;
  logic             at_last;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] prev;
  logic             one_hot;
  logic             valid;

  assign last    = len_q - CNT_W'(1);
  assign at_last = (CNT_W'(idx_q) == last);
  assign cur     = mem[idx_q];
  assign prev    = mem[AW'(last)];
  assign one_hot = $onehot(pattern);

  // Level 3 deliberately behaves like level 1.
  always_comb begin
    valid = 1'b0;
    case (lvl_q)
      2'd0:    valid = 1'b1;
      2'd2:    valid = one_hot && ((len_q == '0) || (pattern != prev));
      default: valid = one_hot;
    endcase
  end

`ifdef SIMON_STRIKE_EN
  logic strike_q;
  assign strike = strike_q;
`else
  assign strike = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= StInput;
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      lvl_q   <= level;
`ifdef SIMON_STRIKE_EN
      strike_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StInput: begin
          if (valid) begin
            mem[AW'(len_q)] <= pattern;
            len_q           <= len_q + CNT_W'(1);
            idx_q           <= '0;
            state_q         <= StPlayback;
          end
        end
        StPlayback: begin
          if (at_last) begin
            idx_q   <= '0;
            state_q <= StRepeat;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        StRepeat: begin
          if (pattern == cur) begin
            if (at_last) begin
              score_q <= len_q;
              idx_q   <= '0;
              state_q <= (len_q == CNT_W'(DEPTH)) ? StWin : StInput;
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end else begin
            idx_q <= '0;
`ifdef SIMON_STRIKE_EN
            // First miss replays the sequence; a second miss ends the game.
            if (!strike_q) begin
              strike_q <= 1'b1;
              state_q  <= StPlayback;
            end else begin
              state_q <= StDone;
            end
`else
            state_q <= StDone;
`endif
          end
        end
        StDone, StWin: begin
          idx_q <= at_last ? '0 : idx_q + AW'(1);
        end
        default: state_q <= StInput;
      endcase
    end
  end

  always_comb begin
    mode_leds = 3'b000;
    case (state_q)
      StInput:    mode_leds = 3'b001;
      StPlayback: mode_leds = 3'b010;
      StRepeat:   mode_leds = 3'b100;
      StDone:     mode_leds = 3'b111;
      StWin:      mode_leds = 3'b110;
      default:    mode_leds = 3'b000;
    endcase
  end

  assign pattern_leds = ((state_q == StInput) || (state_q == StRepeat)) ? pattern : cur;
  assign score        = score_q;

endmodule

// File: tb/tb_simon_game_param.sv
// Scoreboard bench for simon_game_param: default-depth instance plus a DEPTH=4 instance.
module tb_simon_game_param;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] level = 2'd0;
  logic [3:0] pattern = 4'b0000;

  logic [3:0] leds_a, leds_b;
  logic [2:0] mode_a, mode_b;
  logic [6:0] score_a;
  logic [2:0] score_b;
  logic       strike_a, strike_b;

  simon_game_param dut (
    .pclk(pclk), .rst(rst), .level(level), .pattern(pattern),
    .pattern_leds(leds_a), .mode_leds(mode_a), .score(score_a), .strike(strike_a)
  );

  simon_game_param #(.DEPTH(4)) dut4 (
    .pclk(pclk), .rst(rst), .level(level), .pattern(pattern),
    .pattern_leds(leds_b), .mode_leds(mode_b), .score(score_b), .strike(strike_b)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit         sel;
    logic [2:0] mode;
    logic [3:0] leds;
    int         score;
    logic       strike;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef SIMON_STRIKE_EN
  localparam bit StrikeOn = 1'b1;
`else
  localparam bit StrikeOn = 1'b0;
`endif

  // Inputs change on the falling edge; the next rising edge consumes them.
  task automatic step(input bit r, input logic [1:0] lv, input logic [3:0] p, input bit sel,
                      input logic [2:0] m, input logic [3:0] l, input int s, input bit k,
                      input string nm);
    exp_t e;
    @(negedge pclk);
    rst     = r;
    level   = lv;
    pattern = p;
    e.sel = sel; e.mode = m; e.leds = l; e.score = s; e.strike = k; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: sample just after each rising edge while inputs are still held.
  initial begin
    exp_t e;
    logic [2:0] am;
    logic [3:0] al;
    int         as;
    logic       ak;
    forever begin
      @(posedge pclk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        am = e.sel ? mode_b : mode_a;
        al = e.sel ? leds_b : leds_a;
        as = e.sel ? int'(score_b) : int'(score_a);
        ak = e.sel ? strike_b : strike_a;
        checks += 4;
        if (am !== e.mode) begin
          errors++;
          $display("FAIL %s mode: got %b expected %b", e.name, am, e.mode);
        end
        if (al !== e.leds) begin
          errors++;
          $display("FAIL %s leds: got %b expected %b", e.name, al, e.leds);
        end
        if (as != e.score) begin
          errors++;
          $display("FAIL %s score: got %0d expected %0d", e.name, as, e.score);
        end
        if (ak !== e.strike) begin
          errors++;
          $display("FAIL %s strike: got %b expected %b", e.name, ak, e.strike);
        end
      end
    end
  end

  initial begin
    logic [3:0] pats [4];
    logic [2:0] m;
    logic [3:0] l;
    int         s;
    pats[0] = 4'b0011; pats[1] = 4'b0110; pats[2] = 4'b1100; pats[3] = 4'b1001;

    // Level 0 basic round.
    step(1, 2'd0, 4'b0000, 0, 3'b001, 4'b0000, 0, 0, "rst_p0");
    step(1, 2'd0, 4'b0001, 0, 3'b001, 4'b0001, 0, 0, "rst_p1");
    step(0, 2'd0, 4'b0001, 0, 3'b010, 4'b0001, 0, 0, "l0_enter");
    step(0, 2'd0, 4'b0000, 0, 3'b100, 4'b0000, 0, 0, "l0_to_repeat");
    step(0, 2'd0, 4'b0001, 0, 3'b001, 4'b0001, 1, 0, "l0_repeat_ok");

    // Level 1: one-hot only, then a failed repeat.
    step(1, 2'd1, 4'b0000, 0, 3'b001, 4'b0000, 0, 0, "l1_rst");
    step(0, 2'd0, 4'b0011, 0, 3'b001, 4'b0011, 0, 0, "l1_rej_0011");
    step(0, 2'd0, 4'b0001, 0, 3'b010, 4'b0001, 0, 0, "l1_enter1");
    step(0, 2'd0, 4'b0000, 0, 3'b100, 4'b0000, 0, 0, "l1_rep1");
    step(0, 2'd0, 4'b0001, 0, 3'b001, 4'b0001, 1, 0, "l1_ok1");
    step(0, 2'd0, 4'b1010, 0, 3'b001, 4'b1010, 1, 0, "l1_rej_1010");
    step(0, 2'd0, 4'b1000, 0, 3'b010, 4'b0001, 1, 0, "l1_pb0");
    step(0, 2'd0, 4'b0000, 0, 3'b010, 4'b1000, 1, 0, "l1_pb1");
    step(0, 2'd0, 4'b0000, 0, 3'b100, 4'b0000, 1, 0, "l1_rep2");
    step(0, 2'd0, 4'b0001, 0, 3'b100, 4'b0001, 1, 0, "l1_rep2_0");
    if (StrikeOn) begin
      step(0, 2'd0, 4'b0100, 0, 3'b010, 4'b0001, 1, 1, "stk_miss1");
      step(0, 2'd0, 4'b0000, 0, 3'b010, 4'b1000, 1, 1, "stk_pb1");
      step(0, 2'd0, 4'b0000, 0, 3'b100, 4'b0000, 1, 1, "stk_rep");
      step(0, 2'd0, 4'b0001, 0, 3'b100, 4'b0001, 1, 1, "stk_rep0");
      step(0, 2'd0, 4'b1000, 0, 3'b001, 4'b1000, 2, 1, "stk_ok");
      step(0, 2'd0, 4'b0100, 0, 3'b010, 4'b0001, 2, 1, "stk_pb_a");
      step(0, 2'd0, 4'b0000, 0, 3'b010, 4'b1000, 2, 1, "stk_pb_b");
      step(0, 2'd0, 4'b0000, 0, 3'b010, 4'b0100, 2, 1, "stk_pb_c");
      step(0, 2'd0, 4'b0000, 0, 3'b100, 4'b0000, 2, 1, "stk_rep3");
      step(0, 2'd0, 4'b0010, 0, 3'b111, 4'b0001, 2, 1, "stk_miss2");
    end else begin
      step(0, 2'd0, 4'b0100, 0, 3'b111, 4'b0001, 1, 0, "l1_miss_done");
      step(0, 2'd0, 4'b0000, 0, 3'b111, 4'b1000, 1, 0, "done_cyc1");
      step(0, 2'd0, 4'b0000, 0, 3'b111, 4'b0001, 1, 0, "done_cyc2");
      step(0, 2'd0, 4'b0000, 0, 3'b111, 4'b1000, 1, 0, "done_cyc3");
    end

    // Level 2: no immediate repeat of the previous entry.
    step(1, 2'd2, 4'b0000, 0, 3'b001, 4'b0000, 0, 0, "l2_rst");
    step(0, 2'd0, 4'b0010, 0, 3'b010, 4'b0010, 0, 0, "l2_enter");
    step(0, 2'd0, 4'b0000, 0, 3'b100, 4'b0000, 0, 0, "l2_rep");
    step(0, 2'd0, 4'b0010, 0, 3'b001, 4'b0010, 1, 0, "l2_ok");
    step(0, 2'd0, 4'b0010, 0, 3'b001, 4'b0010, 1, 0, "l2_rej_same");
    step(0, 2'd0, 4'b0011, 0, 3'b001, 4'b0011, 1, 0, "l2_rej_multi");
    step(0, 2'd0, 4'b0100, 0, 3'b010, 4'b0010, 1, 0, "l2_accept");

    // Level 3 acts as level 1.
    step(1, 2'd3, 4'b0000, 0, 3'b001, 4'b0000, 0, 0, "l3_rst");
    step(0, 2'd0, 4'b0000, 0, 3'b001, 4'b0000, 0, 0, "l3_rej_zero");
    step(0, 2'd0, 4'b0001, 0, 3'b010, 4'b0001, 0, 0, "l3_accept");

    // Reset in the middle of REPEAT with idx=1.
    step(1, 2'd0, 4'b0000, 0, 3'b001, 4'b0000, 0, 0, "mr_rst");
    step(0, 2'd0, 4'b0001, 0, 3'b010, 4'b0001, 0, 0, "mr_e1");
    step(0, 2'd0, 4'b0000, 0, 3'b100, 4'b0000, 0, 0, "mr_r1");
    step(0, 2'd0, 4'b0001, 0, 3'b001, 4'b0001, 1, 0, "mr_ok1");
    step(0, 2'd0, 4'b0010, 0, 3'b010, 4'b0001, 1, 0, "mr_pb0");
    step(0, 2'd0, 4'b0000, 0, 3'b010, 4'b0010, 1, 0, "mr_pb1");
    step(0, 2'd0, 4'b0000, 0, 3'b100, 4'b0000, 1, 0, "mr_rep");
    step(0, 2'd0, 4'b0001, 0, 3'b100, 4'b0001, 1, 0, "mr_rep_idx1");
    step(1, 2'd0, 4'b0100, 0, 3'b001, 4'b0100, 0, 0, "mr_reset");
    step(0, 2'd0, 4'b1000, 0, 3'b010, 4'b1000, 0, 0, "mr_len0");
    step(0, 2'd0, 4'b0000, 0, 3'b100, 4'b0000, 0, 0, "mr_len1");

    // DEPTH=4 instance: four correct rounds reach WIN.
    step(1, 2'd0, 4'b0000, 1, 3'b001, 4'b0000, 0, 0, "d4_rst");
    for (int r = 1; r <= 4; r++) begin
      step(0, 2'd0, pats[r-1], 1, 3'b010, pats[0], r - 1, 0, "d4_enter");
      for (int i = 1; i < r; i++) step(0, 2'd0, 4'b0000, 1, 3'b010, pats[i], r - 1, 0, "d4_pb");
      step(0, 2'd0, 4'b0000, 1, 3'b100, 4'b0000, r - 1, 0, "d4_to_rep");
      for (int i = 0; i < r; i++) begin
        if (i < r - 1) begin
          m = 3'b100; l = pats[i]; s = r - 1;
        end else if (r == 4) begin
          m = 3'b110; l = pats[0]; s = 4;
        end else begin
          m = 3'b001; l = pats[i]; s = r;
        end
        step(0, 2'd0, pats[i], 1, m, l, s, 0, "d4_rep");
      end
    end
    for (int i = 1; i <= 5; i++)
      step(0, 2'd0, 4'b0000, 1, 3'b110, pats[i % 4], 4, 0, "d4_win_cyc");

    repeat (4) @(posedge pclk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
